ceil_div_seq: RTL and testbench
===============================

Name: ceil_div_seq

Overview:
- Multi-cycle iterative unsigned divider. Returns ceil(dividend/divisor) as a hardware datapath.
- Run-time counterpart of the constant function ceil_div in cf_math_pkg.
- Used by DMA, burst-splitting and tiling logic that computes beat and tile counts from runtime sizes.
- Radix-2 restoring division, one quotient bit per cycle, followed by a ceil-adjust step.
- Valid/ready handshakes on input and output. At most one operation in flight.

Parameters:
- Width, 32, operand and result width in bits (>=2).
- CntWidth, cf_math_pkg::idx_width(Width), iteration counter width (derived, not overridable).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous abort of any in-flight operation.
- in_valid_i  in  1  operands valid.
- in_ready_o  out  1  block can accept operands.
- dividend_i  in  Width  unsigned dividend.
- divisor_i  in  Width  unsigned divisor.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts result.
- quotient_o  out  Width  ceil(dividend/divisor).
- exact_o  out  1  remainder was zero.
- div_zero_o  out  1  divisor was zero.

Behaviour:
- Interface: one clock, clk_i. Reset rst_ni is asynchronous and active-low.
- Reset values:
  - State IDLE.
  - in_ready_o=1, out_valid_o=0.
  - quotient_o=0, exact_o=0, div_zero_o=0.
  - Internal registers (quotient, remainder, divisor, counter) = 0.
- FSM states: IDLE, BUSY, ADJ, DONE.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i && in_ready_o: latch operands.
  - divisor_i==0: go to DONE. quotient = all ones, div_zero_o=1, exact_o=0.
  - Otherwise: go to BUSY. Counter = Width-1, remainder = 0.
- BUSY, one iteration per cycle, MSB first:
  - rem' = {rem, next dividend bit}.
  - If rem' >= divisor: subtract, quotient bit = 1. Else quotient bit = 0.
  - Counter decrements. At counter==0, go to ADJ.
  - BUSY lasts exactly Width cycles.
  - Remainder register is Width+1 bits, so the compare never overflows.
- ADJ:
  - exact = (remainder==0).
  - quotient += !exact. Go to DONE.
  - No overflow: divisor>=1 gives ceil(a/b) <= a < 2^Width.
- DONE:
  - out_valid_o=1. quotient_o, exact_o and div_zero_o are held stable while out_ready_i=0.
  - On out_ready_i: go to IDLE.
- Latency: input handshake in cycle T gives out_valid_o high from T+Width+2 (normal) or T+1 (divide by zero).
- Throughput: in_ready_o=0 in BUSY, ADJ and DONE. Input and output handshakes never occur in the same cycle. The next accept is the cycle after the output handshake.
- Outputs are registered. No combinational path from in_valid_i or out_ready_i to any output.
- flush_i:
  - Highest priority. From any state, go to IDLE next cycle.
  - out_valid_o=0 next cycle. Result flags cleared.
  - flush_i together with in_valid_i in IDLE: operands are not accepted.
- Asynchronous reset mid-operation returns all state to reset values. No result is emitted.
- dividend_i==0 with divisor_i!=0 takes the normal path: quotient 0, exact_o=1.
- Assertions (simulation only, excluded from synthesis): operands and result stable while the corresponding valid is high and ready is low; Width>=2.

Decomposition:
- cf_math_pkg (existing) provides idx_width for CntWidth. No new typedefs are added there.
- FSM state enum is local to the module.
- Sub-module ceil_div_step: combinational single restoring-division step. Inputs: remainder, divisor, next bit. Outputs: new remainder, quotient bit. Keeps the FSM file small and lets a later radix-4 variant instantiate two steps per cycle.

Test Plan:
- 7/2, out_ready_i=1 -> quotient_o=4, exact_o=0, div_zero_o=0. out_valid_o rises exactly Width+2 cycles after the accept.
- 8/2 -> quotient_o=4, exact_o=1. 0/5 -> quotient_o=0, exact_o=1.
- 5/0 -> out_valid_o the cycle after accept: quotient_o=32'hFFFF_FFFF, div_zero_o=1, exact_o=0.
- 32'hFFFF_FFFF/1 -> 32'hFFFF_FFFF exact. 32'hFFFF_FFFF/32'h8000_0000 -> 2, exact_o=0.
- Backpressure: out_ready_i low for 10 cycles -> outputs stable, in_ready_o=0. Release -> IDLE next cycle; back-to-back op 9/4 -> 3.
- Mid-operation: flush_i in BUSY cycle 5 -> IDLE, no out_valid_o, next op 10/3 -> 4. Repeat with rst_ni low in BUSY -> same recovery. Then 1000 random operand pairs vs reference model ceil((a+b-1)/b).

Source files
------------

// File: rtl/cf_math_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cf_math_pkg
// Brief    : Constant-function math helpers shared by sizing and counting logic.
// Revision : 1.0 - initial release
// ============================================================================
package cf_math_pkg;

    // Bits needed to index num_idx items; never less than one bit.
    function automatic int unsigned idx_width(input int unsigned num_idx);
        return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
    endfunction

    // Elaboration-time ceiling division; ceil_div_seq is its run-time twin.
    function automatic longint unsigned ceil_div(input longint unsigned dividend,
                                                 input longint unsigned divisor);
        return (dividend + divisor - 64'd1) / divisor;
    endfunction

endpackage : cf_math_pkg
`default_nettype wire

// File: rtl/ceil_div_step.sv
`default_nettype none
// ============================================================================
// Module   : ceil_div_step
// Brief    : One combinational radix-2 restoring-division step.
// Revision : 1.0 - initial release
// ============================================================================
module ceil_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic [WIDTH-1:0] i_divisor,
    input  logic             i_next_bit,
    output logic [WIDTH:0]   o_rem,
    output logic             o_quot_bit
);

    // One extra headroom bit so the shifted remainder and compare never wrap.
    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_div_ext;
    logic             w_ge;

    assign w_shift   = {i_rem, i_next_bit};
    assign w_div_ext = {2'b00, i_divisor};
    assign w_ge      = (w_shift >= w_div_ext);

    // Restore (keep the shifted value) when the divisor does not fit.
    always_comb begin
        o_quot_bit = w_ge;
        o_rem      = w_ge ? (WIDTH+1)'(w_shift - w_div_ext) : (WIDTH+1)'(w_shift);
    end

endmodule : ceil_div_step
`default_nettype wire

// File: rtl/ceil_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : ceil_div_seq
// Brief    : Multi-cycle unsigned ceil(dividend/divisor) with valid/ready
//            handshakes; one quotient bit per cycle then a round-up step.
// Revision : 1.0 - initial release
// ============================================================================
module ceil_div_seq
    import cf_math_pkg::*;
#(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] dividend_i,
    input  logic [Width-1:0] divisor_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] quotient_o,
    output logic             exact_o,
    output logic             div_zero_o
);

    localparam int unsigned CntWidth = idx_width(Width);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ADJ  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              r_state;
    logic [Width-1:0]    r_quot;
    logic [Width:0]      r_rem;
    logic [Width-1:0]    r_div;
    logic [Width-1:0]    r_dvd;
    logic [CntWidth-1:0] r_cnt;

    logic [Width:0]      w_rem_next;
    logic                w_quot_bit;
    logic                w_exact;
    logic [Width-1:0]    w_round_up;

    ceil_div_step #(
        .WIDTH (Width)
    ) u_step (
        .i_rem      (r_rem),
        .i_divisor  (r_div),
        .i_next_bit (r_dvd[Width-1]),
        .o_rem      (w_rem_next),
        .o_quot_bit (w_quot_bit)
    );

    // Any leftover remainder means the floor quotient must be bumped by one.
    always_comb begin
        w_exact    = (r_rem == '0);
        w_round_up = {{(Width-1){1'b0}}, ~w_exact};
    end

    // Control FSM and datapath registers; flush overrides every state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_quot      <= '0;
            r_rem       <= '0;
            r_div       <= '0;
            r_dvd       <= '0;
            r_cnt       <= '0;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
            quotient_o  <= '0;
            exact_o     <= 1'b0;
            div_zero_o  <= 1'b0;
        end else if (flush_i) begin
            r_state     <= IDLE;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
            quotient_o  <= '0;
            exact_o     <= 1'b0;
            div_zero_o  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid_i && in_ready_o) begin
                        r_dvd      <= dividend_i;
                        r_div      <= divisor_i;
                        in_ready_o <= 1'b0;
                        exact_o    <= 1'b0;
                        if (divisor_i == '0) begin
                            // Saturate: report all ones and skip the iteration.
                            r_quot      <= '1;
                            quotient_o  <= '1;
                            div_zero_o  <= 1'b1;
                            out_valid_o <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_quot     <= '0;
                            r_rem      <= '0;
                            r_cnt      <= CntWidth'(Width - 1);
                            div_zero_o <= 1'b0;
                            r_state    <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    r_rem  <= w_rem_next;
                    r_quot <= {r_quot[Width-2:0], w_quot_bit};
                    r_dvd  <= {r_dvd[Width-2:0], 1'b0};
                    r_cnt  <= r_cnt - CntWidth'(1);
                    if (r_cnt == '0) begin
                        r_state <= ADJ;
                    end
                end
                ADJ: begin
                    // divisor >= 1 keeps ceil(a/b) <= a, so this add cannot wrap.
                    quotient_o  <= r_quot + w_round_up;
                    exact_o     <= w_exact;
                    out_valid_o <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        in_ready_o  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    a_width_min : assert property (@(posedge clk_i) Width >= 2);

    a_out_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (out_valid_o && !out_ready_i && !flush_i) |=>
            (out_valid_o && $stable(quotient_o) && $stable(exact_o) && $stable(div_zero_o)));

    a_in_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (in_valid_i && !in_ready_o && !flush_i) |=>
            ($stable(dividend_i) && $stable(divisor_i)));
`endif

endmodule : ceil_div_seq
`default_nettype wire

// File: tb/tb_ceil_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ceil_div_seq
// Brief    : Directed and random self-checking bench for ceil_div_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ceil_div_seq;

    localparam int W = 32;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          flush     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b1;
    logic [W-1:0]  dividend  = '0;
    logic [W-1:0]  divisor   = '0;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  quotient;
    logic          exact;
    logic          div_zero;

    int n_checks = 0;
    int n_errors = 0;

    ceil_div_seq #(
        .Width (W)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .dividend_i  (dividend),
        .divisor_i   (divisor),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .quotient_o  (quotient),
        .exact_o     (exact),
        .div_zero_o  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        int guard = 0;
        while (!in_ready && guard < 200) begin
            tick();
            guard++;
        end
        check("in_ready_wait", in_ready, 1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // lat counts cycles from the accept cycle to the first cycle with out_valid.
    task automatic wait_result(output int lat);
        lat = 1;
        while (!out_valid && lat < W + 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic check_idle_after_reset(input string tag);
        check({tag, "_in_ready"},  in_ready,  1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_quotient"},  quotient,  0);
        check({tag, "_exact"},     exact,     0);
        check({tag, "_div_zero"},  div_zero,  0);
    endtask

    task automatic no_valid_for(input string tag, input int cycles);
        logic seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check(tag, seen, 0);
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_q, input logic exp_ex, input logic exp_dz);
        int lat;
        send(a, b);
        wait_result(lat);
        check({tag, "_latency"},  lat, (b == '0) ? 1 : W + 2);
        check({tag, "_quotient"}, quotient, exp_q);
        check({tag, "_exact"},    exact,    exp_ex);
        check({tag, "_div_zero"}, div_zero, exp_dz);
        if (out_ready) begin
            tick();
            check({tag, "_valid_drop"}, out_valid, 0);
            check({tag, "_ready_back"}, in_ready,  1);
        end
    endtask

    initial begin
        int             lat;
        logic [W-1:0]   ra, rb, eq;
        logic [63:0]    q64;
        logic           eex, edz;

        // Reset state
        repeat (3) tick();
        check_idle_after_reset("reset");
        rst_n = 1'b1;
        tick();

        // Directed vectors, hand-computed
        do_op("d7_2",     32'd7,         32'd2,         32'd4,         1'b0, 1'b0);
        do_op("d8_2",     32'd8,         32'd2,         32'd4,         1'b1, 1'b0);
        do_op("d0_5",     32'd0,         32'd5,         32'd0,         1'b1, 1'b0);
        do_op("d5_0",     32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0, 1'b1);
        do_op("dmax_1",   32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 1'b1, 1'b0);
        do_op("dmax_msb", 32'hFFFF_FFFF, 32'h8000_0000, 32'd2,         1'b0, 1'b0);
        do_op("d1_max",   32'd1,         32'hFFFF_FFFF, 32'd1,         1'b0, 1'b0);

        // Backpressure: 100/7 -> 15, held for 10 cycles
        out_ready = 1'b0;
        send(32'd100, 32'd7);
        wait_result(lat);
        check("bp_latency",  lat, W + 2);
        check("bp_quotient", quotient, 15);
        check("bp_exact",    exact, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_valid",    out_valid, 1);
            check("bp_hold_quotient", quotient,  15);
            check("bp_hold_exact",    exact,     0);
            check("bp_hold_in_ready", in_ready,  0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", out_valid, 0);
        check("bp_release_ready", in_ready,  1);
        do_op("b2b_9_4", 32'd9, 32'd4, 32'd3, 1'b0, 1'b0);

        // Flush together with in_valid in IDLE must not accept
        dividend = 32'd6;
        divisor  = 32'd2;
        in_valid = 1'b1;
        flush    = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_idle_ready", in_ready, 1);
        no_valid_for("flush_idle_no_valid", 40);

        // Flush in BUSY cycle 5
        send(32'd50, 32'd3);
        repeat (4) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_valid", out_valid, 0);
        check("flush_ready", in_ready,  1);
        no_valid_for("flush_no_valid", 40);
        do_op("flush_10_3", 32'd10, 32'd3, 32'd4, 1'b0, 1'b0);

        // Asynchronous reset in BUSY cycle 5
        send(32'd50, 32'd3);
        repeat (4) tick();
        rst_n = 1'b0;
        #2;
        check_idle_after_reset("midrst");
        tick();
        rst_n = 1'b1;
        no_valid_for("midrst_no_valid", 40);
        do_op("rst_10_3", 32'd10, 32'd3, 32'd4, 1'b0, 1'b0);

        // Random operands against ceil((a+b-1)/b)
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            case (i % 4)
                0:       rb = $urandom;
                1:       rb = $urandom_range(1, 16);
                2:       rb = $urandom & 32'h0000_00FF;
                default: rb = ra >> $urandom_range(0, 31);
            endcase
            if (i % 50 == 7) ra = '0;
            if (rb == '0) begin
                eq  = '1;
                eex = 1'b0;
                edz = 1'b1;
            end else begin
                q64 = ({32'd0, ra} + {32'd0, rb} - 64'd1) / {32'd0, rb};
                eq  = q64[W-1:0];
                eex = ((ra % rb) == '0);
                edz = 1'b0;
            end
            do_op("rand", ra, rb, eq, eex, edz);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_ceil_div_seq
`default_nettype wire
